operand_fetch_stage: RTL and testbench

- Issue-side partner of the 32x32 RISC-V register file: reads it rather than writing it.
- Accepts decoded-stream instructions over valid/ready, drives the file's two combinational read addresses and registers operands into an execute-bound pipeline register.
- Tracks pending destination writes in a scoreboard and stalls on RAW/WAW hazards.
- Snoops the write-back port feeding the register file to clear scoreboard bits and, optionally, forward data.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/operand_fetch_stage_scoreboard.sv | 33 +++
 rtl/operand_fetch_stage.sv | 120 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the issue-side pipeline: opcodes and widths.
package riscv_pkg;

  localparam int RV_XLEN  = 32;
  localparam int RV_NREG  = 32;
  localparam int RV_REG_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module operand_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREG  = RV_NREG,
  parameter int REG_W = RV_REG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en,
  input  logic [REG_W-1:0]  set_idx,
  input  logic              clr_en,
  input  logic [REG_W-1:0]  clr_idx,
  output logic [NREG-1:0]   pending
);

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = {{(NREG-1){1'b0}}, 1'b1} << set_idx;
    if (clr_en) clr_mask = {{(NREG-1){1'b0}}, 1'b1} << clr_idx;
  end

  // Set is OR-ed after the clear so a same-cycle set on the same index wins.
  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= ((pending & ~clr_mask) | set_mask) & {{(NREG-1){1'b1}}, 1'b0};
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: reads the register file, stalls on RAW/WAW via a scoreboard.
// Optional write-back forwarding is enabled by defining OPERAND_FETCH_BYPASS_EN.
module operand_fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int NREG = RV_NREG
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  input  logic [XLEN-1:0] rf_r1,
  input  logic [XLEN-1:0] rf_r2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic            out_wr_en
);

  function automatic logic [XLEN-1:0] pick_operand(logic [4:0] idx, logic fwd,
                                                   logic [XLEN-1:0] rf, logic [XLEN-1:0] wb);
    if (idx == 5'd0) return '0;
    else if (fwd)    return wb;
    else             return rf;
  endfunction

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            uses_rs1, uses_rs2, wr_en;
  logic            wb_hit, fwd1, fwd2, waw_clr, hazard, issue;
  logic [NREG-1:0] pending;

  logic            vld_p1;
  logic [31:0]     pc_p1, instr_p1;
  logic [XLEN-1:0] rs1_val_p1, rs2_val_p1;
  logic [4:0]      rd_p1;
  logic            wr_en_p1;

  assign rf_a1 = in_instr[19:15];
  assign rf_a2 = in_instr[24:20];

  always_comb begin
    opcode   = in_instr[6:0];
    rd       = in_instr[11:7];
    rs1      = in_instr[19:15];
    rs2      = in_instr[24:20];
    uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    uses_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    wr_en    = !(opcode inside {OPC_STORE, OPC_BRANCH}) && (rd != 5'd0);
    wb_hit   = wb_valid && (wb_rd != 5'd0);
`ifdef OPERAND_FETCH_BYPASS_EN
    fwd1     = wb_hit && (wb_rd == rs1);
    fwd2     = wb_hit && (wb_rd == rs2);
    waw_clr  = wb_hit && (wb_rd == rd);
`else
    fwd1     = 1'b0;
    fwd2     = 1'b0;
    waw_clr  = 1'b0;
`endif
    hazard   = (uses_rs1 && (rs1 != 5'd0) && pending[rs1] && !fwd1) ||
               (uses_rs2 && (rs2 != 5'd0) && pending[rs2] && !fwd2) ||
               (wr_en && pending[rd] && !waw_clr);
    in_ready = (!vld_p1 || out_ready) && !hazard;
    issue    = in_valid && in_ready;
  end

  operand_scoreboard #(.NREG(NREG), .REG_W(5)) u_sb (
    .clock   (clock),
    .reset   (reset),
    .set_en  (issue && wr_en),
    .set_idx (rd),
    .clr_en  (wb_hit),
    .clr_idx (wb_rd),
    .pending (pending)
  );

  // ---- stage p1: execute-bound operand bundle ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      instr_p1   <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      rd_p1      <= '0;
      wr_en_p1   <= 1'b0;
    end else if (issue) begin
      vld_p1     <= 1'b1;
      pc_p1      <= in_pc;
      instr_p1   <= in_instr;
      rs1_val_p1 <= pick_operand(rs1, fwd1, rf_r1, wb_data);
      rs2_val_p1 <= pick_operand(rs2, fwd2, rf_r2, wb_data);
      rd_p1      <= rd;
      wr_en_p1   <= wr_en;
    end else if (out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign out_instr   = instr_p1;
  assign out_rs1_val = rs1_val_p1;
  assign out_rs2_val = rs2_val_p1;
  assign out_rd      = rd_p1;
  assign out_wr_en   = wr_en_p1;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow OPERAND_FETCH_BYPASS_EN.
module tb_operand_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_r1, rf_r2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_wr_en;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADDI_X2 = 32'h0070_0113;  // addi x2,x0,7
  localparam logic [31:0] I_ADD_X3  = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] I_ADD_X0  = 32'h0000_0033;  // add  x0,x0,x0
  localparam logic [31:0] I_ADDI_X6 = 32'h0000_0313;  // addi x6,x0,0
  localparam logic [31:0] I_ADDI_X7 = 32'h0000_0393;  // addi x7,x0,0
  localparam logic [31:0] I_ADDI_X5 = 32'h0010_0293;  // addi x5,x0,1

  operand_fetch_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_r1(rf_r1), .rf_r2(rf_r2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_wr_en(out_wr_en)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_instr = I_ADDI_X1; in_pc = 32'h0;
    rf_r1 = 32'h0; rf_r2 = 32'h0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    out_ready = 1'b1;
    tick(); tick();
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_pending", dut.pending, 32'h0);
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_out_rd", {27'b0, out_rd}, 32'h0);

    // back-to-back independent issues
    reset = 1'b0; rf_r1 = 32'hDEAD; rf_r2 = 32'hDEAD;
    #1;
    check("rf_a1_comb", {27'b0, rf_a1}, 32'h0);
    check("rf_a2_comb", {27'b0, rf_a2}, 32'h5);
    check("b2b_ready0", {31'b0, in_ready}, 32'h1);
    tick();
    check("b2b_valid0", {31'b0, out_valid}, 32'h1);
    check("b2b_rd0", {27'b0, out_rd}, 32'h1);
    check("b2b_rs1_x0", out_rs1_val, 32'h0);
    check("b2b_wr_en0", {31'b0, out_wr_en}, 32'h1);
    in_instr = I_ADDI_X2; in_pc = 32'h4;
    #1;
    check("b2b_ready1", {31'b0, in_ready}, 32'h1);
    tick();
    check("b2b_valid1", {31'b0, out_valid}, 32'h1);
    check("b2b_rd1", {27'b0, out_rd}, 32'h2);
    check("b2b_pc1", out_pc, 32'h4);
    check("b2b_pending", dut.pending, 32'h6);

    // retire x2, bundle drains
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h7;
    tick();
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    check("clr_x2_pending", dut.pending, 32'h2);

    // RAW on x1
    wb_valid = 1'b0; in_valid = 1'b1; in_instr = I_ADD_X3; in_pc = 32'h8;
    rf_r1 = 32'h1111; rf_r2 = 32'h2222;
    #1;
    check("raw_stall_ready", {31'b0, in_ready}, 32'h0);
    tick();
    check("raw_stall_valid", {31'b0, out_valid}, 32'h0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    check("raw_wb_ready", {31'b0, in_ready}, 32'h1);
    tick();
`else
    check("raw_wb_ready", {31'b0, in_ready}, 32'h0);
    tick();
    check("raw_wb_no_issue", {31'b0, out_valid}, 32'h0);
    check("raw_wb_cleared", dut.pending, 32'h0);
    wb_valid = 1'b0; rf_r1 = 32'h1234;
    #1;
    check("raw_next_ready", {31'b0, in_ready}, 32'h1);
    tick();
`endif
    check("raw_valid", {31'b0, out_valid}, 32'h1);
    check("raw_rs1", out_rs1_val, 32'h1234);
    check("raw_rs2", out_rs2_val, 32'h2222);
    check("raw_rd", {27'b0, out_rd}, 32'h3);
    check("raw_pending", dut.pending, 32'h8);

    // x0 handling, wb to x0 ignored
    in_instr = I_ADD_X0; in_pc = 32'hC; rf_r1 = 32'hDEAD; rf_r2 = 32'hDEAD;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    tick();
    check("x0_valid", {31'b0, out_valid}, 32'h1);
    check("x0_rs1", out_rs1_val, 32'h0);
    check("x0_rs2", out_rs2_val, 32'h0);
    check("x0_wr_en", {31'b0, out_wr_en}, 32'h0);
    check("x0_pending", dut.pending, 32'h8);

    // backpressure
    wb_valid = 1'b0; in_instr = I_ADDI_X6; in_pc = 32'h20;
    tick();
    check("bp_issue_instr", out_instr, I_ADDI_X6);
    out_ready = 1'b0; in_instr = I_ADDI_X7; in_pc = 32'h24;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready_low", {31'b0, in_ready}, 32'h0);
      tick();
      check("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      check("bp_hold_instr", out_instr, I_ADDI_X6);
      check("bp_hold_pc", out_pc, 32'h20);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'h1);
    tick();
    check("bp_next_instr", out_instr, I_ADDI_X7);
    check("bp_pending", dut.pending, 32'hC8);

    // WAW with same-cycle write-back of the destination
    in_instr = I_ADDI_X5; in_pc = 32'h28;
    tick();
    check("waw_first_pc", out_pc, 32'h28);
    check("waw_first_pending", dut.pending, 32'hE8);
    in_pc = 32'h2C; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1;
    #1;
`ifdef OPERAND_FETCH_BYPASS_EN
    check("waw_ready", {31'b0, in_ready}, 32'h1);
    tick();
`else
    check("waw_ready", {31'b0, in_ready}, 32'h0);
    tick();
    check("waw_stall_valid", {31'b0, out_valid}, 32'h0);
    check("waw_stall_pending", dut.pending, 32'hC8);
    wb_valid = 1'b0;
    tick();
`endif
    check("waw_second_pc", out_pc, 32'h2C);
    check("waw_second_valid", {31'b0, out_valid}, 32'h1);
    check("waw_pending_kept", dut.pending, 32'hE8);

    // consumed with no new issue -> valid drops
    wb_valid = 1'b0; in_valid = 1'b0;
    tick();
    check("idle_valid_drop", {31'b0, out_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
